// File: rtl/digit_result_filter.sv
// Debounces per-frame 3-digit recognition results: locks after STABLE_FRAMES identical valid frames, drops after MISS_FRAMES invalid ones.
// Optional seven-segment scan driver enabled by defining DIGIT_SEG_SCAN_EN.
module digit_result_filter #(
    parameter int STABLE_FRAMES = 4,
    parameter int MISS_FRAMES   = 8,
    parameter int SCAN_DIV      = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic [7:0] disp_data1,
    input  logic [7:0] disp_data2,
    input  logic [7:0] disp_data3,
    output logic       frame_end,
    output logic [3:0] result_d1,
    output logic [3:0] result_d2,
    output logic [3:0] result_d3,
    output logic       locked,
    output logic       result_valid,
    output logic [2:0] seg_sel,
    output logic [7:0] seg_data
);

    localparam logic [3:0]  LP_STABLE = 4'(STABLE_FRAMES);
    localparam logic [3:0]  LP_MISS   = 4'(MISS_FRAMES);
    localparam logic [11:0] LP_BLANK  = 12'hFFF;

    logic        r_vs_d;
    logic        r_frame_end;
    logic        r_result_valid;
    logic        r_locked;
    logic [11:0] r_cand;
    logic [11:0] r_result;
    logic [3:0]  r_match;
    logic [3:0]  r_miss;

    logic        w_fall;
    logic        w_frame_ok;
    logic [11:0] w_code;
    logic [11:0] w_cand_next;
    logic [3:0]  w_match_next;
    logic [3:0]  w_miss_next;
    logic        w_do_lock;
    logic        w_do_unlock;

    // Frame classification and next counter values, all evaluated on the vsync fall cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_cand_next  = r_cand;
        w_match_next = r_match;
        w_miss_next  = r_miss;

        w_fall     = r_vs_d & ~per_frame_vsync;
        w_frame_ok = (disp_data1 < 8'd10) && (disp_data2 < 8'd10) && (disp_data3 < 8'd10);
        w_code     = {disp_data1[3:0], disp_data2[3:0], disp_data3[3:0]};

        if (w_frame_ok) begin
            w_miss_next = 4'd0;
            if (w_code == r_cand) begin
                w_match_next = (r_match >= LP_STABLE) ? LP_STABLE : r_match + 4'd1;
            end else begin
                w_cand_next  = w_code;
                w_match_next = 4'd1;
            end
        end else begin
            w_match_next = 4'd0;
            w_miss_next  = (r_miss >= LP_MISS) ? LP_MISS : r_miss + 4'd1;
        end

        w_do_lock   = w_frame_ok && (w_match_next == LP_STABLE) &&
                      (!r_locked || (r_result != w_cand_next));
        w_do_unlock = !w_frame_ok && (w_miss_next == LP_MISS);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d         <= 1'b0;
            r_frame_end    <= 1'b0;
            r_result_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_cand         <= LP_BLANK;
            r_result       <= LP_BLANK;
            r_match        <= 4'd0;
            r_miss         <= 4'd0;
        end else begin
            r_vs_d         <= per_frame_vsync;
            r_frame_end    <= w_fall;
            r_result_valid <= w_fall && w_do_lock;
            if (w_fall) begin
                r_cand  <= w_cand_next;
                r_match <= w_match_next;
                r_miss  <= w_miss_next;
                if (w_do_lock) begin
                    r_result <= w_cand_next;
                    r_locked <= 1'b1;
                end else if (w_do_unlock) begin
                    r_result <= LP_BLANK;
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign frame_end    = r_frame_end;
    assign result_valid = r_result_valid;
    assign locked       = r_locked;
    assign result_d1    = r_result[11:8];
    assign result_d2    = r_result[7:4];
    assign result_d3    = r_result[3:0];

`ifdef DIGIT_SEG_SCAN_EN
    localparam logic [15:0] LP_SCAN_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] r_presc;
    logic [1:0]  r_slot;
    logic [2:0]  r_seg_sel;
    logic [7:0]  r_seg_data;
    logic [3:0]  w_slot_digit;
    logic [2:0]  w_slot_sel;

    // Active-low {dp,g,f,e,d,c,b,a}; anything outside 0..9 (including the unlocked 4'hF) shows a dash.
    function automatic logic [7:0] f_seg(input logic [3:0] i_digit);
        case (i_digit)
            4'd0:    f_seg = 8'hC0;
            4'd1:    f_seg = 8'hF9;
            4'd2:    f_seg = 8'hA4;
            4'd3:    f_seg = 8'hB0;
            4'd4:    f_seg = 8'h99;
            4'd5:    f_seg = 8'h92;
            4'd6:    f_seg = 8'h82;
            4'd7:    f_seg = 8'hF8;
            4'd8:    f_seg = 8'h80;
            4'd9:    f_seg = 8'h90;
            default: f_seg = 8'hBF;
        endcase
    endfunction

    always_comb begin
        w_slot_digit = r_result[11:8];
        w_slot_sel   = 3'b110;
        case (r_slot)
            2'd1: begin
                w_slot_digit = r_result[7:4];
                w_slot_sel   = 3'b101;
            end
            2'd2: begin
                w_slot_digit = r_result[3:0];
                w_slot_sel   = 3'b011;
            end
            default: begin
                w_slot_digit = r_result[11:8];
                w_slot_sel   = 3'b110;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= 16'd0;
            r_slot     <= 2'd0;
            r_seg_sel  <= 3'b111;
            r_seg_data <= 8'hFF;
        end else begin
            if (r_presc == LP_SCAN_LAST) begin
                r_presc <= 16'd0;
                r_slot  <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            r_seg_sel  <= w_slot_sel;
            r_seg_data <= f_seg(w_slot_digit);
        end
    end

    assign seg_sel  = r_seg_sel;
    assign seg_data = r_seg_data;
`else
    logic w_unused_scan;
    assign w_unused_scan = (SCAN_DIV > 0);
    assign seg_sel       = 3'b111;
    assign seg_data      = 8'hFF;
`endif

endmodule

// File: tb/tb_digit_result_filter.sv
// Directed bench for digit_result_filter: main instance at default thresholds plus a
// second instance with STABLE_FRAMES = MISS_FRAMES = 1 driven by the same frames.
module tb_digit_result_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_frame_vsync;
    logic [7:0] disp_data1, disp_data2, disp_data3;

    logic       frame_end, locked, result_valid;
    logic [3:0] result_d1, result_d2, result_d3;
    logic [2:0] seg_sel;
    logic [7:0] seg_data;

    logic       s_frame_end, s_locked, s_result_valid;
    logic [3:0] s_result_d1, s_result_d2, s_result_d3;
    logic [2:0] s_seg_sel;
    logic [7:0] s_seg_data;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int fe_cnt    = 0;

    logic fe_now, fe_after, rv_now, s_rv_now;

    digit_result_filter #(.STABLE_FRAMES(4), .MISS_FRAMES(8), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(per_frame_vsync),
        .disp_data1(disp_data1), .disp_data2(disp_data2), .disp_data3(disp_data3),
        .frame_end(frame_end), .result_d1(result_d1), .result_d2(result_d2),
        .result_d3(result_d3), .locked(locked), .result_valid(result_valid),
        .seg_sel(seg_sel), .seg_data(seg_data)
    );

    digit_result_filter #(.STABLE_FRAMES(1), .MISS_FRAMES(1), .SCAN_DIV(4)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(per_frame_vsync),
        .disp_data1(disp_data1), .disp_data2(disp_data2), .disp_data3(disp_data3),
        .frame_end(s_frame_end), .result_d1(s_result_d1), .result_d2(s_result_d2),
        .result_d3(s_result_d3), .locked(s_locked), .result_valid(s_result_valid),
        .seg_sel(s_seg_sel), .seg_data(s_seg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && result_valid) pulse_cnt++;
        if (rst_n && frame_end) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One frame: vsync high with the codes present, then the fall; captures the evaluation-cycle outputs.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        per_frame_vsync = 1'b1;
        disp_data1 = a;
        disp_data2 = b;
        disp_data3 = c;
        repeat (4) @(negedge clk);
        per_frame_vsync = 1'b0;
        @(posedge clk);
        #1;
        fe_now   = frame_end;
        rv_now   = result_valid;
        s_rv_now = s_result_valid;
        @(posedge clk);
        #1;
        fe_after = frame_end;
        @(negedge clk);
        disp_data1 = 8'hEE;
        disp_data2 = 8'hEE;
        disp_data3 = 8'hEE;
    endtask

    function automatic logic [31:0] res();
        return 32'({result_d1, result_d2, result_d3});
    endfunction

    function automatic logic [31:0] s_res();
        return 32'({s_result_d1, s_result_d2, s_result_d3});
    endfunction

    initial begin
        int p0;
        int f0;
        rst_n = 1'b0;
        per_frame_vsync = 1'b0;
        disp_data1 = 8'h00;
        disp_data2 = 8'h00;
        disp_data3 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_result", res(), 32'h0FFF);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_seg_sel", 32'(seg_sel), 32'h7);
        check("rst_seg_data", 32'(seg_data), 32'hFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lock after four identical frames.
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) begin
            run_frame(8'd1, 8'd2, 8'd3);
            check("lock_pre_locked", 32'(locked), 32'd0);
            check("lock_pre_valid", 32'(rv_now), 32'd0);
        end
        check("s1_first_result", s_res(), 32'h0123);
        run_frame(8'd1, 8'd2, 8'd3);
        check("lock_frame_end", 32'(fe_now), 32'd1);
        check("lock_frame_end_width", 32'(fe_after), 32'd0);
        check("lock_valid", 32'(rv_now), 32'd1);
        check("lock_result", res(), 32'h0123);
        check("lock_locked", 32'(locked), 32'd1);
        run_frame(8'd1, 8'd2, 8'd3);
        check("lock_repeat_valid", 32'(rv_now), 32'd0);
        check("lock_pulse_count", 32'(pulse_cnt - p0), 32'd1);
        check("s1_same_no_pulse", 32'(s_rv_now), 32'd0);

        // Single-frame misread must not reach the result.
        p0 = pulse_cnt;
        run_frame(8'd7, 8'd2, 8'd3);
        check("s1_misread_valid", 32'(s_rv_now), 32'd1);
        check("s1_misread_result", s_res(), 32'h0723);
        for (int i = 0; i < 3; i++) run_frame(8'd1, 8'd2, 8'd3);
        check("misread_result", res(), 32'h0123);
        check("misread_locked", 32'(locked), 32'd1);
        check("misread_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Value change while locked.
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) begin
            run_frame(8'd4, 8'd5, 8'd6);
            check("change_pre_result", res(), 32'h0123);
            check("change_pre_locked", 32'(locked), 32'd1);
        end
        run_frame(8'd4, 8'd5, 8'd6);
        check("change_valid", 32'(rv_now), 32'd1);
        check("change_result", res(), 32'h0456);
        check("change_locked", 32'(locked), 32'd1);
        check("change_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Vsync held high: no evaluation, state holds.
        f0 = fe_cnt;
        @(negedge clk);
        per_frame_vsync = 1'b1;
        disp_data1 = 8'hFF;
        repeat (40) @(negedge clk);
        check("hold_no_frame_end", 32'(fe_cnt - f0), 32'd0);
        check("hold_result", res(), 32'h0456);
        per_frame_vsync = 1'b0;
        disp_data1 = 8'd4;
        disp_data2 = 8'd5;
        disp_data3 = 8'd6;
        repeat (2) @(negedge clk);

        // Unlock after eight invalid frames, not seven.
        p0 = pulse_cnt;
        run_frame(8'hFF, 8'd5, 8'd6);
        check("s1_unlock_locked", 32'(s_locked), 32'd0);
        check("s1_unlock_result", s_res(), 32'h0FFF);
        for (int i = 0; i < 6; i++) run_frame(8'hFF, 8'd5, 8'd6);
        check("miss7_locked", 32'(locked), 32'd1);
        check("miss7_result", res(), 32'h0456);
        run_frame(8'hFF, 8'd5, 8'd6);
        check("miss8_locked", 32'(locked), 32'd0);
        check("miss8_result", res(), 32'h0FFF);
        check("miss8_valid", 32'(rv_now), 32'd0);
        check("miss_pulses", 32'(pulse_cnt - p0), 32'd0);
        run_frame(8'd5, 8'd10, 8'd0);
        check("code10_invalid_locked", 32'(s_locked), 32'd0);

        // Reset mid-sequence discards accumulated matches.
        for (int i = 0; i < 3; i++) run_frame(8'd9, 8'd9, 8'd9);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;
        run_frame(8'd9, 8'd9, 8'd9);
        check("midrst_one_locked", 32'(locked), 32'd0);
        check("midrst_one_valid", 32'(rv_now), 32'd0);
        run_frame(8'd9, 8'd9, 8'd9);
        run_frame(8'd9, 8'd9, 8'd9);
        check("midrst_three_locked", 32'(locked), 32'd0);
        run_frame(8'd9, 8'd9, 8'd9);
        check("midrst_four_locked", 32'(locked), 32'd1);
        check("midrst_four_valid", 32'(rv_now), 32'd1);
        check("midrst_four_result", res(), 32'h0999);

`ifdef DIGIT_SEG_SCAN_EN
        begin
            int n110, n101, n011;
            logic [7:0] exp_seg;
            for (int i = 0; i < 4; i++) run_frame(8'd0, 8'd1, 8'd2);
            n110 = 0; n101 = 0; n011 = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                case (seg_sel)
                    3'b110:  begin n110++; exp_seg = 8'hC0; end
                    3'b101:  begin n101++; exp_seg = 8'hF9; end
                    3'b011:  begin n011++; exp_seg = 8'hA4; end
                    default: exp_seg = 8'h00;
                endcase
                check("scan_seg_data", 32'(seg_data), 32'(exp_seg));
            end
            check("scan_slot0_cycles", 32'(n110), 32'd4);
            check("scan_slot1_cycles", 32'(n101), 32'd4);
            check("scan_slot2_cycles", 32'(n011), 32'd4);
        end
`else
        check("tied_seg_sel", 32'(seg_sel), 32'h7);
        check("tied_seg_data", 32'(seg_data), 32'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
